// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle CPU phase sequencer: state encoding,
// state width and default performance-counter width.
package cpu_seq_pkg;

  localparam int STATE_W   = 3;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

endpackage

// File: rtl/seq_perf_cnt.sv
// Saturating performance counter: counts enabled cycles, sticks at all-ones,
// clears only on reset.
module seq_perf_cnt
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB phase controller for the MIPS-subset CPU.
// Performance counters exist only when CPU_SEQ_PERF_CNT_EN is defined.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             reg_wr_req,
  output logic             imem_rd,
  output logic             ir_load,
  output logic             pc_en,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             reg_wr_en,
  output logic             instr_done,
  output logic             busy,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e r_state;
  logic   r_mem_ld;
  logic   r_mem_st;
  state_e w_bound_next;
  logic   w_retire;

  assign w_bound_next = halt_req ? S_HALT : S_FETCH;

  // Memory class is captured when leaving EXEC so the MEM strobes are pure
  // state decodes; branch beats memory, load beats store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mem_ld <= 1'b0;
      r_mem_st <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   if (start) r_state <= S_FETCH;
        S_FETCH:  if (imem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (is_branch) begin
            r_state <= w_bound_next;
          end else if (is_load || is_store) begin
            r_state  <= S_MEM;
            r_mem_ld <= is_load;
            r_mem_st <= is_store && !is_load;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) r_state <= r_mem_st ? w_bound_next : S_WB;
        end
        S_WB:     r_state <= w_bound_next;
        S_HALT:   if (start) r_state <= S_FETCH;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign state_o = r_state;
  assign imem_rd = (r_state == S_FETCH);
  assign dmem_rd = (r_state == S_MEM) && r_mem_ld;
  assign dmem_wr = (r_state == S_MEM) && r_mem_st;
  assign busy    = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                   (r_state == S_EXEC)  || (r_state == S_MEM)    ||
                   (r_state == S_WB);

  // Retire cycle doubles as the instruction boundary: the only pc_en of the instruction.
  assign w_retire   = ((r_state == S_EXEC) && is_branch) ||
                      ((r_state == S_MEM) && r_mem_st && dmem_ready) ||
                      (r_state == S_WB);
  assign pc_en      = w_retire;
  assign instr_done = w_retire;
  assign ir_load    = (r_state == S_FETCH) && imem_ready;
  assign reg_wr_en  = (r_state == S_WB) && reg_wr_req;

`ifdef CPU_SEQ_PERF_CNT_EN
  seq_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (busy),
    .o_cnt (cycle_cnt)
  );

  seq_perf_cnt #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_retire),
    .o_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = {CNT_W{1'b0}};
  assign instret_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus randomized instruction mix
// checked against a phase-sequence model of each instruction class.
module tb_cpu_sequencer;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
`ifdef CPU_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk, rst_n, start, halt_req, imem_ready, dmem_ready;
  logic is_load, is_store, is_branch, reg_wr_req;
  logic imem_rd, ir_load, pc_en, dmem_rd, dmem_wr, reg_wr_en, instr_done, busy;
  logic [2:0] state_o;
  logic [31:0] cycle_cnt, instret_cnt;

  int checks = 0;
  int errors = 0;
  int mcyc = 0;
  int mret = 0;
  int cyc_idx = 0;
  int pc_n = 0;
  int pc_at = 0;

  cpu_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .reg_wr_req(reg_wr_req), .imem_rd(imem_rd), .ir_load(ir_load),
    .pc_en(pc_en), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .reg_wr_en(reg_wr_en), .instr_done(instr_done), .busy(busy),
    .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Irrelevant inputs get random values; callers then override what matters.
  task automatic noise(input int hmode);
    halt_req   = (hmode == 2) ? 1'b1 : (hmode == 1) ? 1'($urandom % 2) : 1'b0;
    start      = 1'($urandom % 2);
    imem_ready = 1'($urandom % 2);
    dmem_ready = 1'($urandom % 2);
  endtask

  // Checks one cycle's outputs (inputs already applied), then advances to the next negedge.
  task automatic cyc(input logic [2:0] st, input bit ird, input bit ild, input bit pce,
                     input bit rwe, input bit drd, input bit dwr);
    bit b;
    b = (st >= FETCH) && (st <= WB);
    #1;
    cyc_idx++;
    if (pc_en === 1'b1) begin
      pc_n++;
      pc_at = cyc_idx;
    end
    chk("state_o", 32'(state_o), 32'(st));
    chk("imem_rd", 32'(imem_rd), 32'(ird));
    chk("ir_load", 32'(ir_load), 32'(ild));
    chk("pc_en", 32'(pc_en), 32'(pce));
    chk("instr_done", 32'(instr_done), 32'(pce));
    chk("reg_wr_en", 32'(reg_wr_en), 32'(rwe));
    chk("dmem_rd", 32'(dmem_rd), 32'(drd));
    chk("dmem_wr", 32'(dmem_wr), 32'(dwr));
    chk("busy", 32'(busy), 32'(b));
    chk("cycle_cnt", cycle_cnt, PERF ? 32'(mcyc) : 32'd0);
    chk("instret_cnt", instret_cnt, PERF ? 32'(mret) : 32'd0);
    if (b) mcyc++;
    if (pce) mret++;
    @(negedge clk);
  endtask

  // cls: 0 ALU, 1 branch, 2 lw, 3 sw. iw/dw: wait cycles on imem/dmem ready.
  task automatic run_instr(input int cls, input int iw, input int dw, input bit hlt, input int hmode);
    bit ld, st, wr;
    int explat;
    ld = (cls == 2);
    st = (cls == 3);
    wr = 1'($urandom % 2);
    is_branch  = (cls == 1);
    is_load    = ld || ((cls == 1) && ($urandom % 2 == 1));
    is_store   = st || (((cls == 1) || (cls == 2)) && ($urandom % 2 == 1));
    reg_wr_req = wr;
    cyc_idx = 0;
    pc_n = 0;
    pc_at = 0;
    for (int i = 0; i <= iw; i++) begin
      noise(hmode);
      imem_ready = (i == iw);
      cyc(FETCH, 1, (i == iw), 0, 0, 0, 0);
    end
    noise(hmode);
    cyc(DECODE, 0, 0, 0, 0, 0, 0);
    noise(hmode);
    if (cls == 1) halt_req = hlt;
    cyc(EXEC, 0, 0, (cls == 1), 0, 0, 0);
    if (ld || st) begin
      for (int j = 0; j <= dw; j++) begin
        noise(hmode);
        dmem_ready = (j == dw);
        if (st && (j == dw)) halt_req = hlt;
        cyc(MEM, 0, 0, (st && (j == dw)), 0, ld, st);
      end
    end
    if ((cls == 0) || (cls == 2)) begin
      noise(hmode);
      halt_req = hlt;
      cyc(WB, 0, 0, 1, wr, 0, 0);
    end
    explat = ((cls == 1) ? 3 : (cls == 2) ? 5 : 4) + iw + ((ld || st) ? dw : 0);
    chk("latency", 32'(pc_at), 32'(explat));
    chk("pc_en_count", 32'(pc_n), 32'd1);
    if (hlt) begin
      noise(1);
      start = 1'b0;
      cyc(HALT, 0, 0, 0, 0, 0, 0);
      noise(1);
      start = 1'b1;
      cyc(HALT, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; reg_wr_req = 1'b0;
    #2;
    chk("rst_state", 32'(state_o), 32'(IDLE));
    chk("rst_strobes", {24'd0, imem_rd, ir_load, pc_en, dmem_rd, dmem_wr, reg_wr_en, instr_done, busy}, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_instret_cnt", instret_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(IDLE, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    cyc(IDLE, 0, 0, 0, 0, 0, 0);

    run_instr(0, 0, 0, 1'b0, 0);   // ALU add, zero wait
    run_instr(2, 0, 3, 1'b0, 0);   // lw, dmem_ready low 3 cycles
    run_instr(3, 0, 0, 1'b0, 0);   // sw, immediate ready
    run_instr(1, 0, 0, 1'b0, 0);   // taken branch
    run_instr(2, 1, 2, 1'b1, 2);   // lw with halt_req held high, then resume

    // Reset in MEM of a store with dmem_wr asserted
    halt_req = 1'b0; start = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
    is_load = 1'b0; is_store = 1'b1; is_branch = 1'b0; reg_wr_req = 1'b1;
    cyc(FETCH, 1, 1, 0, 0, 0, 0);
    cyc(DECODE, 0, 0, 0, 0, 0, 0);
    cyc(EXEC, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_dmem_wr_before", 32'(dmem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dmem_wr", 32'(dmem_wr), 32'd0);
    chk("mid_rst_state", 32'(state_o), 32'(IDLE));
    chk("mid_rst_pc_en", 32'(pc_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("mid_rst_instret_cnt", instret_cnt, 32'd0);
    mcyc = 0;
    mret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    cyc(IDLE, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    cyc(IDLE, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      run_instr(int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                ($urandom % 5) == 0, int'($urandom % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed time %0t expected < 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
